// File: rtl/reg_write_sequencer.sv
// reg_write_sequencer
// Turns a one-cycle write-back request into one or two timed register-file
// writes, driving the destination-mux select, the write-data source select
// and the RegWrite strobe. Handles the two-write classes (POP, XCHG), a
// per-write DataValid timeout and the reserved class.
module reg_write_sequencer #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Start,
   input  logic [2:0] WbClass,
   input  logic       DataValid,
   output logic [2:0] RegDest,
   output logic [1:0] WbSrc,
   output logic       RegWrite,
   output logic       Busy,
   output logic       Done,
   output logic       Err
);

   typedef enum logic [1:0] {IDLE, WR1, WR2, FIN} state_t;

   localparam logic [2:0] CLS_RTYPE = 3'b000;
   localparam logic [2:0] CLS_ITYPE = 3'b001;
   localparam logic [2:0] CLS_LOAD  = 3'b010;
   localparam logic [2:0] CLS_JAL   = 3'b011;
   localparam logic [2:0] CLS_PUSH  = 3'b100;
   localparam logic [2:0] CLS_POP   = 3'b101;
   localparam logic [2:0] CLS_XCHG  = 3'b110;
   localparam logic [2:0] CLS_RSVD  = 3'b111;

   // Last wait-counter value before a write is abandoned.
   localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

   state_t     state, next_state;
   logic [2:0] cls_q;
   logic [3:0] wait_cnt;
   logic       err_pend;
   logic       err_set;
   logic       timeout_hit;
   logic       in_write;
   logic [4:0] sel_next;

   // {RegDest, WbSrc} for the first or second write of a class.
   function automatic logic [4:0] write_sel(input logic [2:0] cls, input logic second);
      logic [4:0] sel;
      sel = 5'b000_00;
      if (!second) begin
         case (cls)
            CLS_RTYPE: sel = 5'b001_00;
            CLS_ITYPE: sel = 5'b000_00;
            CLS_LOAD:  sel = 5'b000_01;
            CLS_JAL:   sel = 5'b010_10;
            CLS_PUSH:  sel = 5'b011_11;
            CLS_POP:   sel = 5'b000_01;
            CLS_XCHG:  sel = 5'b100_00;
            default:   sel = 5'b000_00;
         endcase
      end else begin
         case (cls)
            CLS_POP:  sel = 5'b011_11;
            CLS_XCHG: sel = 5'b000_01;
            default:  sel = 5'b000_00;
         endcase
      end
      return sel;
   endfunction

   assign in_write    = (state == WR1) || (state == WR2);
   assign timeout_hit = !DataValid && (wait_cnt == WAIT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic, including reserved-class and timeout error flags.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      next_state = state;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               if (WbClass == CLS_RSVD) begin
                  next_state = FIN;
                  err_set    = 1'b1;
               end else begin
                  next_state = WR1;
               end
            end
         end
         WR1: begin
            if (DataValid) begin
               next_state = ((cls_q == CLS_POP) || (cls_q == CLS_XCHG)) ? WR2 : FIN;
            end else if (timeout_hit) begin
               next_state = FIN;
               err_set    = 1'b1;
            end
         end
         WR2: begin
            if (DataValid) begin
               next_state = FIN;
            end else if (timeout_hit) begin
               next_state = FIN;
               err_set    = 1'b1;
            end
         end
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Select values for the state being entered, so they are stable all state.
   always_comb begin
      sel_next = 5'b000_00;
      case (next_state)
         WR1:     sel_next = write_sel((state == IDLE) ? WbClass : cls_q, 1'b0);
         WR2:     sel_next = write_sel(cls_q, 1'b1);
         default: sel_next = 5'b000_00;
      endcase
   end

   // Latched class, wait counter, pending error and registered selects.
   always_ff @(posedge clk) begin
      if (reset) begin
         cls_q    <= 3'b000;
         wait_cnt <= 4'd0;
         err_pend <= 1'b0;
         RegDest  <= 3'b000;
         WbSrc    <= 2'b00;
      end else begin
         if ((state == IDLE) && Start) cls_q <= WbClass;
         if (next_state != state)           wait_cnt <= 4'd0;
         else if (in_write && !DataValid)   wait_cnt <= wait_cnt + 4'd1;
         if (state != FIN) err_pend <= err_set;
         {RegDest, WbSrc} <= sel_next;
      end
   end

   // Output decode: Mealy write strobe, status flags.
   always_comb begin
      RegWrite = in_write && DataValid && !reset;
      Busy     = (state != IDLE);
      Done     = (state == FIN);
      Err      = (state == FIN) && err_pend;
   end

endmodule

// File: tb/tb_reg_write_sequencer.sv
// tb_reg_write_sequencer
// Directed bench for reg_write_sequencer with TIMEOUT=4. Inputs change 2 time
// units after a rising edge; outputs are checked 1 unit later.
module tb_reg_write_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       Start;
   logic [2:0] WbClass;
   logic       DataValid;
   logic [2:0] RegDest;
   logic [1:0] WbSrc;
   logic       RegWrite;
   logic       Busy;
   logic       Done;
   logic       Err;

   int tests = 0;
   int fails = 0;

   reg_write_sequencer #(.TIMEOUT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .Start     (Start),
      .WbClass   (WbClass),
      .DataValid (DataValid),
      .RegDest   (RegDest),
      .WbSrc     (WbSrc),
      .RegWrite  (RegWrite),
      .Busy      (Busy),
      .Done      (Done),
      .Err       (Err)
   );

   always #5 clk = ~clk;

   // Advance to the next cycle: 2 units after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Compare {RegDest, WbSrc, RegWrite, Busy, Done, Err} against expected.
   task automatic expect_out(input string tag, input logic [2:0] dest, input logic [1:0] src,
                             input logic wr, input logic busy, input logic done, input logic err);
      logic [8:0] obs, exp;
      #1;
      obs = {RegDest, WbSrc, RegWrite, Busy, Done, Err};
      exp = {dest, src, wr, busy, done, err};
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed dest/src/wr/busy/done/err=%b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; Start = 1'b0; WbClass = 3'b000; DataValid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      expect_out("reset_state", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // R-type, DataValid high
      reset = 1'b0; Start = 1'b1; WbClass = 3'b000; DataValid = 1'b1;
      cyc(); Start = 1'b0;
      expect_out("rtype_wr1", 3'b001, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
      expect_out("rtype_fin", 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc();
      expect_out("rtype_idle", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // POP with 3 cycles of memory latency
      Start = 1'b1; WbClass = 3'b101; DataValid = 1'b0;
      cyc(); Start = 1'b0;
      expect_out("pop_wait1", 3'b000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      expect_out("pop_wait2", 3'b000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      expect_out("pop_wait3", 3'b000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(); DataValid = 1'b1;
      expect_out("pop_write1", 3'b000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
      expect_out("pop_write2", 3'b011, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(); DataValid = 1'b0;
      expect_out("pop_fin", 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc();
      expect_out("pop_idle", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // LOAD timeout (TIMEOUT=4): 4 cycles in WR1, then Done+Err
      Start = 1'b1; WbClass = 3'b010; DataValid = 1'b0;
      cyc(); Start = 1'b0;
      expect_out("tmo_wr1_c1", 3'b000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      expect_out("tmo_wr1_c2", 3'b000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      expect_out("tmo_wr1_c3", 3'b000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      expect_out("tmo_wr1_c4", 3'b000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      expect_out("tmo_fin_err", 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
      cyc();
      expect_out("tmo_idle", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reserved class: Done+Err next cycle, DataValid ignored
      Start = 1'b1; WbClass = 3'b111; DataValid = 1'b1;
      cyc(); Start = 1'b0;
      expect_out("rsvd_fin_err", 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
      cyc(); DataValid = 1'b0;
      expect_out("rsvd_idle", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // JAL with a Start pulse (POP) during WR1 that must be ignored
      Start = 1'b1; WbClass = 3'b011; DataValid = 1'b0;
      cyc(); Start = 1'b1; WbClass = 3'b101;
      expect_out("jal_wr1_wait", 3'b010, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(); Start = 1'b0; DataValid = 1'b1;
      expect_out("jal_write", 3'b010, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(); DataValid = 1'b0;
      expect_out("jal_fin", 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc();
      expect_out("jal_no_requeue", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // XCHG interrupted by reset in WR2
      Start = 1'b1; WbClass = 3'b110; DataValid = 1'b0;
      cyc(); Start = 1'b0; DataValid = 1'b1;
      expect_out("xchg_write1", 3'b100, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(); DataValid = 1'b0;
      expect_out("xchg_wr2_wait", 3'b000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      reset = 1'b1; DataValid = 1'b1;
      expect_out("xchg_wr2_in_reset", 3'b000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      expect_out("xchg_after_reset", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0; DataValid = 1'b0;
      cyc();
      expect_out("xchg_no_done", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Back-to-back LOAD then PUSH, second Start in the first Busy=0 cycle
      Start = 1'b1; WbClass = 3'b010; DataValid = 1'b1;
      cyc(); Start = 1'b0;
      expect_out("b2b_load_write", 3'b000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc();
      expect_out("b2b_load_fin", 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(); Start = 1'b1; WbClass = 3'b100;
      expect_out("b2b_idle_start", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(); Start = 1'b0;
      expect_out("b2b_push_write", 3'b011, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(); DataValid = 1'b0;
      expect_out("b2b_push_fin", 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc();
      expect_out("b2b_idle", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_write_sequencer.md
# reg_write_sequencer

Sequences register-bank write-back for the multicycle CPU datapath. It turns a one-cycle write-back request carrying an instruction class into one or two timed register-file writes. For each write it drives the RegDest select of the destination mux, the write-data source select and the RegWrite strobe. It sits between the main control FSM, which issues requests, and the register bank / destination-mux pair. It also owns the two-write sequences (POP, XCHG) and a per-write timeout on slow write data.

## Interface
- TIMEOUT, default 15: maximum cycles one write waits for DataValid; legal range 1..15.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  write-back request; sampled only in IDLE.
- WbClass  input  3  instruction class, sampled with Start.
- DataValid  input  1  write data for the current write is valid this cycle.
- RegDest  output  3  destination-mux select: 000 RT, 001 RD, 010 $31, 011 $29, 100 RS.
- WbSrc  output  2  write-data source: 00 ALU, 01 MEM, 10 PC, 11 SP±4.
- RegWrite  output  1  register-bank write enable.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle completion pulse.
- Err  output  1  high only together with Done, for timeout or reserved class.

## Operation
- States: IDLE, WR1, WR2, FIN.
- **Class table** (WbClass: first write → optional second write, shown as RegDest/WbSrc):
  - 000 R-type: 001/00.
  - 001 I-type: 000/00.
  - 010 LOAD: 000/01.
  - 011 JAL: 010/10.
  - 100 PUSH: 011/11.
  - 101 POP: 000/01, then 011/11.
  - 110 XCHG: 100/00, then 000/01.
  - 111 reserved: no write, Err.
- **IDLE**:
  - Start=1 latches WbClass.
  - Class 111: go to FIN with Err pending.
  - Otherwise: go to WR1.
  - Start=0: stay in IDLE.
- **WR1 / WR2**:
  - RegDest/WbSrc are registered from the latched class and state; they are stable for the whole state.
  - RegWrite = DataValid (Mealy, combinational from DataValid and state).
  - When DataValid=1: WR1 goes to WR2 for POP/XCHG, otherwise to FIN. WR2 always goes to FIN.
- **Timeout**:
  - A 4-bit wait counter clears on entry to WR1/WR2 and increments on each cycle with DataValid=0.
  - If DataValid=0 and the counter equals TIMEOUT-1: go to FIN with Err pending, with no write that cycle.
  - A second write is abandoned if the first write times out.
- **FIN**: Done=1; Err=1 if pending; go to IDLE next cycle.
- Start outside IDLE is ignored and is not queued.
- Outputs in IDLE/FIN: RegDest=000, WbSrc=00, RegWrite=0.
- **Reset**:
  - From any state, the state goes to IDLE at the reset edge.
  - Reset values: RegDest=000, WbSrc=00, RegWrite=0, Busy=0, Done=0, Err=0, wait counter=0, latched class=000.
  - A write in progress is dropped; RegWrite stays 0 while reset is high.

## Timing
- Start at edge N; WR1 from N+1 with RegDest/WbSrc valid.
- With DataValid held high:
  - Single write: RegWrite in cycle N+1, Done in N+2, IDLE in N+3.
  - Two writes: RegWrite in N+1 and N+2, Done in N+3.
  - Class 111: Done+Err in N+1.
- Each write state lasts 1..TIMEOUT cycles. RegWrite is high for at most one cycle per write state.
- Earliest next accepted Start is the first cycle after FIN, i.e. when Busy=0.
- DataValid is ignored in IDLE and FIN.

## Test plan
- **Reset, then R-type**: reset=1 for 2 cycles, then Start with WbClass=000 and DataValid=1. Required: RegDest=001 and RegWrite=1 exactly in cycle N+1; Done=1 in N+2 with Err=0; Busy=0 in N+3.
- **POP with memory latency**: Start WbClass=101, DataValid low 3 cycles then high, then high immediately.
  - First write: 000/01 with RegWrite at N+4.
  - Second write: 011/11 with RegWrite at N+5.
  - Done at N+6.
- **Timeout with TIMEOUT=4**: Start WbClass=010, DataValid=0 forever. Required: 4 cycles in WR1, no RegWrite, Done=1 and Err=1 in N+5.
- **Reserved class and ignored start**:
  - Start WbClass=111 gives Done=Err=1 at N+1 and no RegWrite.
  - Start pulsed during WR1 of a JAL (RegDest=010, WbSrc=10) must not start a second sequence.
- **Reset mid-XCHG**: assert reset in WR2. Required: next cycle IDLE, all outputs at reset values, and no Done pulse.
- **Back-to-back**: LOAD then PUSH, with the second Start in the first Busy=0 cycle. Required: second sequence accepted, RegDest 000 then 011 in successive write states.
